// File: rtl/xeng_acc_framer.sv
// Cuts a valid-qualified parallel sample stream into 2^SERIAL_ACC_LEN_BITS-sample accumulation windows with sync/last strobes.
// Latency: every output registered, exactly 1 cycle after its input sample.
// Backpressure: none; consumer must accept every cycle. Optional XENG_FRAMER_ZERO_FILL_EN pads mid-window gaps with zero samples.
module xeng_acc_framer #(
   parameter int SERIAL_ACC_LEN_BITS = 7,
   parameter int P_FACTOR_BITS       = 2,
   parameter int BITWIDTH            = 4,
   parameter int N_POLS              = 2,
   parameter int WIN_CNT_BITS        = 16,
   localparam int INPUT_WIDTH        = N_POLS * BITWIDTH * 2 * (1 << P_FACTOR_BITS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic                    sync_in,
   input  logic                    valid_in,
   input  logic [INPUT_WIDTH-1:0]  din,
   output logic [INPUT_WIDTH-1:0]  dout,
   output logic                    valid_out,
   output logic                    sync_out,
   output logic                    last_out,
   output logic [WIN_CNT_BITS-1:0] win_cnt,
   output logic                    err_gap
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   localparam logic [SERIAL_ACC_LEN_BITS-1:0] CNT_ZERO = '0;
   localparam logic [SERIAL_ACC_LEN_BITS-1:0] CNT_LAST = '1;

   state_t                         state;
   state_t                         state_nxt;
   logic [SERIAL_ACC_LEN_BITS-1:0] cnt;
   logic [SERIAL_ACC_LEN_BITS-1:0] cnt_nxt;
   logic [INPUT_WIDTH-1:0]         dout_nxt;
   logic                           valid_nxt;
   logic                           sync_nxt;
   logic                           last_nxt;
   logic [WIN_CNT_BITS-1:0]        win_nxt;
   logic                           err_nxt;

   logic                           cnt_zero;
   logic                           cnt_last;

   // The clock enable only exists for the Simulink model; the RTL runs every cycle.
   logic                           unused_ce;
   assign unused_ce = ce;

   assign cnt_zero = (cnt == CNT_ZERO);
   assign cnt_last = (cnt == CNT_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: sync arms the framer, the first valid sample starts RUN,
   // a sync without a sample in RUN falls back to waiting for one.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (sync_in) begin
               state_nxt = valid_in ? S_RUN : S_ARM;
            end
         end
         S_ARM: begin
            if (valid_in) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (sync_in && !valid_in) begin
               state_nxt = S_ARM;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Output/next-datapath values for the registered outputs and sample counter.
   always_comb begin
      dout_nxt  = dout;
      valid_nxt = 1'b0;
      sync_nxt  = 1'b0;
      last_nxt  = 1'b0;
      cnt_nxt   = cnt;
      err_nxt   = err_gap;
      // The window index advances on the cycle after the last sample is shown.
      win_nxt   = last_out ? (win_cnt + WIN_CNT_BITS'(1)) : win_cnt;

      case (state)
         S_IDLE, S_ARM: begin
            if (sync_in) begin
               cnt_nxt = CNT_ZERO;
               win_nxt = '0;
            end
            // A sample arriving together with (or after) the arm pulse is sample 0.
            if (valid_in && (sync_in || (state == S_ARM))) begin
               dout_nxt  = din;
               valid_nxt = 1'b1;
               sync_nxt  = 1'b1;
               cnt_nxt   = CNT_ZERO + SERIAL_ACC_LEN_BITS'(1);
            end
         end
         S_RUN: begin
            if (sync_in) begin
               // Restart: the partial window is dropped without a last strobe.
               win_nxt = '0;
               if (!cnt_zero) begin
                  err_nxt = 1'b1;
               end
               if (valid_in) begin
                  dout_nxt  = din;
                  valid_nxt = 1'b1;
                  sync_nxt  = 1'b1;
                  cnt_nxt   = CNT_ZERO + SERIAL_ACC_LEN_BITS'(1);
               end else begin
                  cnt_nxt   = CNT_ZERO;
               end
            end else if (valid_in) begin
               dout_nxt  = din;
               valid_nxt = 1'b1;
               sync_nxt  = cnt_zero;
               last_nxt  = cnt_last;
               cnt_nxt   = cnt + SERIAL_ACC_LEN_BITS'(1);
            end else if (!cnt_zero) begin
               // Missing sample inside a window; a gap on a boundary is legal.
               err_nxt = 1'b1;
`ifdef XENG_FRAMER_ZERO_FILL_EN
               // Pad with a zero sample so window timing downstream is fixed.
               dout_nxt  = '0;
               valid_nxt = 1'b1;
               last_nxt  = cnt_last;
               cnt_nxt   = cnt + SERIAL_ACC_LEN_BITS'(1);
`endif
            end
         end
         default: begin
            cnt_nxt = CNT_ZERO;
         end
      endcase
   end

   // Output and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         dout      <= '0;
         valid_out <= 1'b0;
         sync_out  <= 1'b0;
         last_out  <= 1'b0;
         win_cnt   <= '0;
         err_gap   <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         dout      <= dout_nxt;
         valid_out <= valid_nxt;
         sync_out  <= sync_nxt;
         last_out  <= last_nxt;
         win_cnt   <= win_nxt;
         err_gap   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_xeng_acc_framer.sv
// Directed bench for xeng_acc_framer with 8-sample windows.
// Each step drives one input cycle and samples outputs 1 ns after the edge.
// Expected values are hand-derived per step; zero-fill build changes gap expectations.
module tb_xeng_acc_framer;

   localparam int SAL = 3;
   localparam int PFB = 2;
   localparam int BW  = 4;
   localparam int NP  = 2;
   localparam int WCB = 16;
   localparam int IW  = NP * BW * 2 * (1 << PFB);

`ifdef XENG_FRAMER_ZERO_FILL_EN
   localparam bit FILL = 1'b1;
`else
   localparam bit FILL = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           ce;
   logic           sync_in;
   logic           valid_in;
   logic [IW-1:0]  din;
   logic [IW-1:0]  dout;
   logic           valid_out;
   logic           sync_out;
   logic           last_out;
   logic [WCB-1:0] win_cnt;
   logic           err_gap;

   int n_cmp = 0;
   int n_bad = 0;

   xeng_acc_framer #(
      .SERIAL_ACC_LEN_BITS (SAL),
      .P_FACTOR_BITS       (PFB),
      .BITWIDTH            (BW),
      .N_POLS              (NP),
      .WIN_CNT_BITS        (WCB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .sync_in   (sync_in),
      .valid_in  (valid_in),
      .din       (din),
      .dout      (dout),
      .valid_out (valid_out),
      .sync_out  (sync_out),
      .last_out  (last_out),
      .win_cnt   (win_cnt),
      .err_gap   (err_gap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] pat(input int k);
      logic [31:0] hi;
      logic [31:0] lo;
      hi = 32'hC0DE0000 + 32'(k);
      lo = 32'h5A5A0000 + 32'(k * 3);
      return {hi, lo};
   endfunction

   task automatic step(input logic s, input logic v, input logic [IW-1:0] d);
      sync_in  = s;
      valid_in = v;
      din      = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      sync_in  = 1'b0;
      valid_in = 1'b0;
      din      = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      ce = 1'b1;
      do_reset();

      // Reset state
      check("rst_valid", 64'(valid_out), 64'(0));
      check("rst_sync",  64'(sync_out),  64'(0));
      check("rst_last",  64'(last_out),  64'(0));
      check("rst_win",   64'(win_cnt),   64'(0));
      check("rst_err",   64'(err_gap),   64'(0));
      check("rst_dout",  64'(dout),      64'(0));

      // IDLE ignores samples
      step(1'b0, 1'b1, pat(99));
      check("idle_valid", 64'(valid_out), 64'(0));
      check("idle_dout",  64'(dout),      64'(0));

      // Test 1: continuous stream, three windows
      for (int k = 0; k < 24; k++) begin
         step(k == 0, 1'b1, pat(k));
         check("t1_valid", 64'(valid_out), 64'(1));
         check("t1_dout",  64'(dout),      64'(pat(k)));
         check("t1_sync",  64'(sync_out),  64'(k % 8 == 0));
         check("t1_last",  64'(last_out),  64'(k % 8 == 7));
         check("t1_win",   64'(win_cnt),   64'(k / 8));
         check("t1_err",   64'(err_gap),   64'(0));
      end

      // Test 2/3: two-cycle gap after sample 3
      do_reset();
      for (int k = 0; k < 4; k++) begin
         step(k == 0, 1'b1, pat(k));
      end
      step(1'b0, 1'b0, pat(50));
      check("t2_gap1_valid", 64'(valid_out), 64'(FILL));
      check("t2_gap1_dout",  64'(dout),      FILL ? 64'(0) : 64'(pat(3)));
      check("t2_gap1_err",   64'(err_gap),   64'(1));
      step(1'b0, 1'b0, pat(51));
      check("t2_gap2_valid", 64'(valid_out), 64'(FILL));
      check("t2_gap2_err",   64'(err_gap),   64'(1));
      for (int k = 4; k < 8; k++) begin
         step(1'b0, 1'b1, pat(k));
         check("t2_valid", 64'(valid_out), 64'(1));
         check("t2_dout",  64'(dout),      64'(pat(k)));
         check("t2_last",  64'(last_out),  FILL ? 64'(k == 5) : 64'(k == 7));
         check("t2_sync",  64'(sync_out),  FILL ? 64'(k == 6) : 64'(0));
         check("t2_err",   64'(err_gap),   64'(1));
      end
      step(1'b0, 1'b1, pat(8));
      step(1'b0, 1'b1, pat(9));
      check("t2_err_sticky", 64'(err_gap), 64'(1));

      // Test 4: re-sync with a sample at window 2 sample 5
      do_reset();
      for (int k = 0; k < 21; k++) begin
         step(k == 0, 1'b1, pat(k));
      end
      check("t4_win_pre", 64'(win_cnt), 64'(2));
      check("t4_err_pre", 64'(err_gap), 64'(0));
      step(1'b1, 1'b1, pat(21));
      check("t4_sync", 64'(sync_out), 64'(1));
      check("t4_win",  64'(win_cnt),  64'(0));
      check("t4_err",  64'(err_gap),  64'(1));
      check("t4_last", 64'(last_out), 64'(0));
      for (int k = 22; k < 30; k++) begin
         step(1'b0, 1'b1, pat(k));
         check("t4_last_n", 64'(last_out), 64'(k - 21 == 7));
         check("t4_sync_n", 64'(sync_out), 64'(k - 21 == 8));
         check("t4_win_n",  64'(win_cnt),  64'(k - 21 >= 8));
      end

      // Test 5: reset mid-window, then re-arm
      do_reset();
      for (int k = 0; k < 3; k++) begin
         step(k == 0, 1'b1, pat(k));
      end
      step(1'b0, 1'b0, pat(60));
      check("t5_err_set", 64'(err_gap), 64'(1));
      rst = 1'b1;
      step(1'b0, 1'b1, pat(61));
      rst = 1'b0;
      check("t5_rst_valid", 64'(valid_out), 64'(0));
      check("t5_rst_sync",  64'(sync_out),  64'(0));
      check("t5_rst_last",  64'(last_out),  64'(0));
      check("t5_rst_win",   64'(win_cnt),   64'(0));
      check("t5_rst_err",   64'(err_gap),   64'(0));
      check("t5_rst_dout",  64'(dout),      64'(0));
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b1, pat(70 + k));
         check("t5_ign_valid", 64'(valid_out), 64'(0));
      end
      step(1'b1, 1'b1, pat(80));
      check("t5_sync",  64'(sync_out),  64'(1));
      check("t5_valid", 64'(valid_out), 64'(1));
      check("t5_dout",  64'(dout),      64'(pat(80)));
      for (int k = 1; k < 8; k++) begin
         step(1'b0, 1'b1, pat(80 + k));
         check("t5_last", 64'(last_out), 64'(k == 7));
      end
      // Gap on a window boundary is legal
      step(1'b0, 1'b0, pat(90));
      check("t5_bnd_valid", 64'(valid_out), 64'(0));
      check("t5_bnd_err",   64'(err_gap),   64'(0));
      step(1'b0, 1'b1, pat(91));
      check("t5_bnd_sync", 64'(sync_out), 64'(1));
      check("t5_bnd_win",  64'(win_cnt),  64'(1));
      check("t5_bnd_err2", 64'(err_gap),  64'(0));
      // Sync without a sample inside a window: abort, wait for next sample
      step(1'b1, 1'b0, pat(92));
      check("t5_abort_valid", 64'(valid_out), 64'(0));
      check("t5_abort_err",   64'(err_gap),   64'(1));
      check("t5_abort_win",   64'(win_cnt),   64'(0));
      step(1'b0, 1'b1, pat(93));
      check("t5_arm_sync", 64'(sync_out), 64'(1));
      check("t5_arm_dout", 64'(dout),     64'(pat(93)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
